// File: rtl/fault_mem_pkg.sv
// fault_mem_pkg: fault codes and descriptor layout shared by the fault-injecting SRAM model.
// Descriptor fields are sized for the widest supported memory (16-bit address, 64-bit word),
// so ADDR_WIDTH must not exceed DESC_ADDR_W and DATA_WIDTH must not exceed 2**DESC_BIT_W.
package fault_mem_pkg;

  localparam int unsigned DESC_ADDR_W = 16;
  localparam int unsigned DESC_BIT_W  = 6;

  typedef enum logic [2:0] {
    FT_NONE  = 3'd0,
    FT_SA0   = 3'd1,
    FT_SA1   = 3'd2,
    FT_TF_UP = 3'd3,
    FT_TF_DN = 3'd4,
    FT_CFIN  = 3'd5,
    FT_NPSF  = 3'd6
  } fault_type_e;

  typedef struct packed {
    fault_type_e            ftype;
    logic [DESC_ADDR_W-1:0] vaddr;
    logic [DESC_BIT_W-1:0]  vbit;
    logic [DESC_ADDR_W-1:0] aaddr;
    logic [DESC_BIT_W-1:0]  abit;
    logic [1:0]             pat;
  } fault_desc_t;

  // Unused code 7 behaves as an empty slot.
  function automatic fault_type_e decode_type(input logic [2:0] code);
    fault_type_e t;
    case (code)
      3'd1:    t = FT_SA0;
      3'd2:    t = FT_SA1;
      3'd3:    t = FT_TF_UP;
      3'd4:    t = FT_TF_DN;
      3'd5:    t = FT_CFIN;
      3'd6:    t = FT_NPSF;
      default: t = FT_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fault_mem_desc_table.sv
// fault_mem_desc_table: runtime-programmable fault descriptor slots.
// A slot written by cfg_en takes effect from the following edge.
module fault_mem_desc_table
  import fault_mem_pkg::*;
#(
  parameter int unsigned N_FAULTS = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  fault_desc_t       cfg_desc,
  output fault_desc_t       desc [N_FAULTS]
);

  // Load the addressed slot; reset empties every slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_FAULTS; i++) begin
        desc[i] <= '0;
      end
    end else if (cfg_en && (32'(cfg_idx) < N_FAULTS)) begin
      desc[cfg_idx] <= cfg_desc;
    end
  end

endmodule

// File: rtl/fault_mem_multi.sv
// fault_mem_multi: behavioural SRAM with N_FAULTS runtime-programmable fault slots
// (SA0/SA1/TF_UP/TF_DN/CFIN/NPSF), used as the MBIST target. Read latency is two edges.
// Optional: define FAULT_MEM_HIT_LOG_EN to add fault_hit / fault_hit_cnt outputs.
module fault_mem_multi
  import fault_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned CAPACITY   = 63,
  parameter int unsigned N_FAULTS   = 4,
  localparam int unsigned IDX_W     = (N_FAULTS > 1) ? $clog2(N_FAULTS) : 1,
  localparam int unsigned BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  cfg_en,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [2:0]            cfg_type,
  input  logic [ADDR_WIDTH-1:0] cfg_vaddr,
  input  logic [BIT_W-1:0]      cfg_vbit,
  input  logic [ADDR_WIDTH-1:0] cfg_aaddr,
  input  logic [BIT_W-1:0]      cfg_abit,
  input  logic [1:0]            cfg_pat
`ifdef FAULT_MEM_HIT_LOG_EN
  ,
  output logic                  fault_hit,
  output logic [15:0]           fault_hit_cnt
`endif
);

  fault_desc_t cfg_desc;
  fault_desc_t desc [N_FAULTS];

  logic                  cmd_valid;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic [DATA_WIDTH-1:0] mem [CAPACITY+1];

  logic [DESC_ADDR_W-1:0] cmd_addr_x;
  logic                   in_range;
  logic [DATA_WIDTH-1:0]  old_word;
  logic [DATA_WIDTH-1:0]  wr_word;
  logic [DATA_WIDTH-1:0]  rd_word;
  logic [N_FAULTS-1:0]    cfin_rmt;
  logic [N_FAULTS-1:0]    v_ok;
  logic [N_FAULTS-1:0]    a_ok;
  logic [N_FAULTS-1:0]    v_sel;
  logic [N_FAULTS-1:0]    a_sel;
  logic [N_FAULTS-1:0]    nb_hi;
  logic [N_FAULTS-1:0]    nb_lo;
  logic [ADDR_WIDTH-1:0]  va [N_FAULTS];
  logic [BIT_W-1:0]       vb [N_FAULTS];
  logic [BIT_W-1:0]       ab [N_FAULTS];

  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_word_q;

  // Widen the config inputs into the package descriptor layout.
  always_comb begin
    cfg_desc       = '0;
    cfg_desc.ftype = decode_type(cfg_type);
    cfg_desc.vaddr = DESC_ADDR_W'(cfg_vaddr);
    cfg_desc.vbit  = DESC_BIT_W'(cfg_vbit);
    cfg_desc.aaddr = DESC_ADDR_W'(cfg_aaddr);
    cfg_desc.abit  = DESC_BIT_W'(cfg_abit);
    cfg_desc.pat   = cfg_pat;
  end

  fault_mem_desc_table #(
    .N_FAULTS (N_FAULTS),
    .IDX_W    (IDX_W)
  ) u_desc_table (
    .clk      (clk),
    .rst      (rst),
    .cfg_en   (cfg_en),
    .cfg_idx  (cfg_idx),
    .cfg_desc (cfg_desc),
    .desc     (desc)
  );

  // Command stage: direction, address and data registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      cmd_valid <= 1'b1;
      cmd_write <= write_read;
      cmd_addr  <= address;
      cmd_wdata <= wdata;
    end
  end

  // Fault evaluation on current array contents; slots applied in ascending index so the
  // highest index wins on a shared bit. CFIN flip detection uses the intended write data.
  always_comb begin
    cmd_addr_x = DESC_ADDR_W'(cmd_addr);
    in_range   = (32'(cmd_addr) <= CAPACITY);
    old_word   = in_range ? mem[cmd_addr] : '0;
    wr_word    = cmd_wdata;
    rd_word    = old_word;
    cfin_rmt   = '0;
    v_ok       = '0;
    a_ok       = '0;
    v_sel      = '0;
    a_sel      = '0;
    nb_hi      = '0;
    nb_lo      = '0;
    for (int unsigned i = 0; i < N_FAULTS; i++) begin
      va[i]    = desc[i].vaddr[ADDR_WIDTH-1:0];
      vb[i]    = desc[i].vbit[BIT_W-1:0];
      ab[i]    = desc[i].abit[BIT_W-1:0];
      v_ok[i]  = (32'(desc[i].vaddr) <= CAPACITY) && (32'(desc[i].vbit) < DATA_WIDTH);
      a_ok[i]  = (32'(desc[i].aaddr) <= CAPACITY) && (32'(desc[i].abit) < DATA_WIDTH);
      v_sel[i] = cmd_valid && in_range && v_ok[i] && (desc[i].vaddr == cmd_addr_x);
      a_sel[i] = cmd_valid && in_range && a_ok[i] && (desc[i].aaddr == cmd_addr_x);
      if (v_ok[i] && (32'(va[i]) < CAPACITY)) begin
        nb_hi[i] = mem[va[i] + ADDR_WIDTH'(1)][vb[i]];
      end
      if (v_ok[i] && (va[i] != '0)) begin
        nb_lo[i] = mem[va[i] - ADDR_WIDTH'(1)][vb[i]];
      end
      if (cmd_write) begin
        case (desc[i].ftype)
          FT_SA0:   if (v_sel[i]) wr_word[vb[i]] = 1'b0;
          FT_SA1:   if (v_sel[i]) wr_word[vb[i]] = 1'b1;
          FT_TF_UP: if (v_sel[i] && !old_word[vb[i]]) wr_word[vb[i]] = 1'b0;
          FT_TF_DN: if (v_sel[i] && old_word[vb[i]]) wr_word[vb[i]] = 1'b1;
          FT_NPSF:  if (v_sel[i] && ({nb_hi[i], nb_lo[i]} == desc[i].pat))
                      wr_word[vb[i]] = old_word[vb[i]];
          FT_CFIN: begin
            if (a_sel[i] && v_ok[i] && (old_word[ab[i]] != cmd_wdata[ab[i]])) begin
              if (desc[i].vaddr == cmd_addr_x) wr_word[vb[i]] = ~wr_word[vb[i]];
              else                             cfin_rmt[i] = 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        case (desc[i].ftype)
          FT_SA0:  if (v_sel[i]) rd_word[vb[i]] = 1'b0;
          FT_SA1:  if (v_sel[i]) rd_word[vb[i]] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Array update: the addressed word plus any coupled victim bits in other words.
  always_ff @(posedge clk) begin
    if (cmd_valid && cmd_write && in_range) begin
      mem[cmd_addr] <= wr_word;
    end
    for (int unsigned i = 0; i < N_FAULTS; i++) begin
      if (cfin_rmt[i]) begin
        mem[va[i]][vb[i]] <= ~mem[va[i]][vb[i]];
      end
    end
  end

  // Read pipeline: capture at array-op edge, publish one edge later; writes hold rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      rd_word_q <= '0;
      rdata     <= '0;
    end else begin
      rd_valid <= cmd_valid && !cmd_write;
      if (cmd_valid && !cmd_write) begin
        rd_word_q <= rd_word;
      end
      if (rd_valid) begin
        rdata <= rd_word_q;
      end
    end
  end

`ifdef FAULT_MEM_HIT_LOG_EN
  logic hit_any;

  // Any slot that changed stored data, read data, or a coupled victim counts as a hit.
  always_comb begin
    hit_any = cmd_valid && ((cmd_write && in_range && (wr_word != cmd_wdata)) ||
                            (|cfin_rmt) ||
                            (!cmd_write && (rd_word != old_word)));
  end

  // Hit pulse and saturating hit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_hit     <= 1'b0;
      fault_hit_cnt <= '0;
    end else begin
      fault_hit <= hit_any;
      if (hit_any && (fault_hit_cnt != '1)) begin
        fault_hit_cnt <= fault_hit_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fault_mem_multi.sv
// tb_fault_mem_multi: directed checks of fault_mem_multi with hand-computed expectations.
// CAPACITY is set to 61 so addresses 62/63 exercise the out-of-range path.
module tb_fault_mem_multi;

  logic       clk;
  logic       rst;
  logic       write_read;
  logic [5:0] address;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       cfg_en;
  logic [1:0] cfg_idx;
  logic [2:0] cfg_type;
  logic [5:0] cfg_vaddr;
  logic [2:0] cfg_vbit;
  logic [5:0] cfg_aaddr;
  logic [2:0] cfg_abit;
  logic [1:0] cfg_pat;
`ifdef FAULT_MEM_HIT_LOG_EN
  logic        fault_hit;
  logic [15:0] fault_hit_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fault_mem_multi #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (6),
    .CAPACITY   (61),
    .N_FAULTS   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .write_read (write_read),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .cfg_en     (cfg_en),
    .cfg_idx    (cfg_idx),
    .cfg_type   (cfg_type),
    .cfg_vaddr  (cfg_vaddr),
    .cfg_vbit   (cfg_vbit),
    .cfg_aaddr  (cfg_aaddr),
    .cfg_abit   (cfg_abit),
    .cfg_pat    (cfg_pat)
`ifdef FAULT_MEM_HIT_LOG_EN
    ,
    .fault_hit     (fault_hit),
    .fault_hit_cnt (fault_hit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Idle cycles are writes to an out-of-range address: dropped and rdata held.
  task automatic set_idle();
    write_read = 1'b1;
    address    = 6'd63;
    wdata      = 8'h00;
  endtask

  task automatic cyc(input logic wr, input logic [5:0] a, input logic [7:0] d);
    write_read = wr;
    address    = a;
    wdata      = d;
    @(negedge clk);
    set_idle();
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    cyc(1'b1, a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [7:0] exp);
    cyc(1'b0, a, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check_eq(tag, rdata, exp);
  endtask

  task automatic set_slot(input logic [1:0] idx, input logic [2:0] typ,
                          input logic [5:0] va, input logic [2:0] vb,
                          input logic [5:0] aa, input logic [2:0] ab,
                          input logic [1:0] pat);
    cfg_idx   = idx;
    cfg_type  = typ;
    cfg_vaddr = va;
    cfg_vbit  = vb;
    cfg_aaddr = aa;
    cfg_abit  = ab;
    cfg_pat   = pat;
    cfg_en    = 1'b1;
    @(negedge clk);
    cfg_en    = 1'b0;
  endtask

  task automatic clr_slot(input logic [1:0] idx);
    set_slot(idx, 3'd0, 6'd0, 3'd0, 6'd0, 3'd0, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    cfg_en = 1'b0;
    cfg_idx = '0; cfg_type = '0; cfg_vaddr = '0; cfg_vbit = '0;
    cfg_aaddr = '0; cfg_abit = '0; cfg_pat = '0;
    set_idle();
    repeat (2) @(negedge clk);
    check_eq("reset_rdata", rdata, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Write then immediate read; rdata changes exactly two edges after the read.
    wr(6'd3, 8'hA5);
    cyc(1'b0, 6'd3, 8'h00);
    @(negedge clk);
    check_eq("lat_t1_hold", rdata, 8'h00);
    @(negedge clk);
    check_eq("lat_t2_data", rdata, 8'hA5);

    // SA1 on bit0 of word 5: forced on write, persists in storage after slot cleared.
    set_slot(2'd0, 3'd2, 6'd5, 3'd0, 6'd0, 3'd0, 2'b00);
    wr(6'd5, 8'h00);
    rd_chk("sa1_read", 6'd5, 8'h01);
    clr_slot(2'd0);
    rd_chk("sa1_stored", 6'd5, 8'h01);

    // Transition faults on bit2 of word 7.
    set_slot(2'd1, 3'd3, 6'd7, 3'd2, 6'd0, 3'd0, 2'b00);
    wr(6'd7, 8'h00);
    wr(6'd7, 8'hFF);
    rd_chk("tf_up", 6'd7, 8'hFB);
    set_slot(2'd1, 3'd4, 6'd7, 3'd2, 6'd0, 3'd0, 2'b00);
    wr(6'd7, 8'hFF);
    wr(6'd7, 8'h00);
    rd_chk("tf_dn", 6'd7, 8'h04);
    clr_slot(2'd1);

    // CFIN: aggressor word 8 bit1, victim word 9 bit4.
    wr(6'd9, 8'h00);
    wr(6'd8, 8'h00);
    set_slot(2'd2, 3'd5, 6'd9, 3'd4, 6'd8, 3'd1, 2'b00);
    wr(6'd8, 8'h02);
    rd_chk("cfin_victim", 6'd9, 8'h10);
    rd_chk("cfin_aggr", 6'd8, 8'h02);
    wr(6'd8, 8'h02);
    rd_chk("cfin_noflip", 6'd9, 8'h10);
    wr(6'd8, 8'h00);
    rd_chk("cfin_fall", 6'd9, 8'h00);
    clr_slot(2'd2);

    // NPSF: victim word 10 bit1 with both neighbours' bit1 set.
    wr(6'd11, 8'h02);
    wr(6'd9, 8'h02);
    wr(6'd10, 8'h00);
    set_slot(2'd3, 3'd6, 6'd10, 3'd1, 6'd0, 3'd0, 2'b11);
    wr(6'd10, 8'h02);
    rd_chk("npsf_block", 6'd10, 8'h00);
    wr(6'd11, 8'h00);
    wr(6'd10, 8'h02);
    rd_chk("npsf_pass", 6'd10, 8'h02);

    // NPSF at word 0: missing lower neighbour reads as 0.
    wr(6'd1, 8'h01);
    wr(6'd0, 8'h00);
    set_slot(2'd3, 3'd6, 6'd0, 3'd0, 6'd0, 3'd0, 2'b10);
    wr(6'd0, 8'h01);
    rd_chk("npsf_edge", 6'd0, 8'h00);
    clr_slot(2'd3);

    // Two slots on one bit: the higher index decides.
    set_slot(2'd0, 3'd1, 6'd12, 3'd3, 6'd0, 3'd0, 2'b00);
    set_slot(2'd1, 3'd2, 6'd12, 3'd3, 6'd0, 3'd0, 2'b00);
    wr(6'd12, 8'h00);
    rd_chk("prio_sa1", 6'd12, 8'h08);
    set_slot(2'd0, 3'd2, 6'd12, 3'd3, 6'd0, 3'd0, 2'b00);
    set_slot(2'd1, 3'd1, 6'd12, 3'd3, 6'd0, 3'd0, 2'b00);
    wr(6'd12, 8'hFF);
    rd_chk("prio_sa0", 6'd12, 8'hF7);
    clr_slot(2'd0);
    clr_slot(2'd1);

    // Stuck-at forces the read output without touching storage.
    wr(6'd13, 8'h00);
    set_slot(2'd0, 3'd2, 6'd13, 3'd7, 6'd0, 3'd0, 2'b00);
    rd_chk("sa1_rdforce", 6'd13, 8'h80);
    clr_slot(2'd0);
    rd_chk("sa1_rdclean", 6'd13, 8'h00);

    // Descriptor loaded on the same edge as the array op does not affect that op.
    write_read = 1'b1; address = 6'd14; wdata = 8'h00;
    @(negedge clk);
    set_idle();
    set_slot(2'd0, 3'd2, 6'd14, 3'd0, 6'd0, 3'd0, 2'b00);
    clr_slot(2'd0);
    rd_chk("cfg_same_edge", 6'd14, 8'h00);

    // Address beyond CAPACITY: write dropped, read returns 0; top valid word works.
    wr(6'd62, 8'hFF);
    rd_chk("oor_read", 6'd62, 8'h00);
    wr(6'd61, 8'h3C);
    rd_chk("cap_read", 6'd61, 8'h3C);

    // Reset while a write sits in the command stage.
    wr(6'd20, 8'h11);
    rd_chk("pre_rst", 6'd20, 8'h11);
    write_read = 1'b1; address = 6'd20; wdata = 8'h77;
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_idle();
    #2;
    check_eq("mid_rst_rdata", rdata, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_chk("rst_drop_wr", 6'd20, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
